// File: rtl/dmem_lsu_pkg.sv
// Shared op/select codes, state encoding and small decode helpers for the
// data-memory load/store unit.
package dmem_lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [2:0] SEL_B = 3'b100;
  localparam logic [2:0] SEL_H = 3'b010;
  localparam logic [2:0] SEL_W = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC    = 2'd1,
    ST_RMW_WR = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // dmem sub-word writes land in the low lanes only, so any other lane needs RMW
  function automatic logic needs_rmw(input logic [2:0] op, input logic [1:0] off);
    logic r;
    case (op)
      OP_B:    r = (off != 2'd0);
      OP_H:    r = off[1];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] store_sel(input logic [2:0] op);
    logic [2:0] s;
    case (op)
      OP_B:    s = SEL_B;
      OP_H:    s = SEL_H;
      default: s = SEL_W;
    endcase
    return s;
  endfunction

  function automatic logic op_illegal(input logic we, input logic [2:0] op,
                                      input logic [1:0] off);
    logic r;
    case (op)
      OP_B:    r = 1'b0;
      OP_H:    r = off[0];
      OP_W:    r = (off != 2'd0);
      OP_BU:   r = we;
      OP_HU:   r = we | off[0];
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lsu_lane.sv
// Combinational lane logic: load extract/extend and store merge into a word.
module lsu_lane
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Load path: pick the addressed lane and extend it
  always_comb begin
    byte_s = 8'd0;
    case (off_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      2'd3:    byte_s = word_i[31:24];
      default: byte_s = 8'd0;
    endcase
    half_s = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (op_i)
      OP_B:    load_o = {{24{byte_s[7]}}, byte_s};
      OP_BU:   load_o = {24'd0, byte_s};
      OP_H:    load_o = {{16{half_s[15]}}, half_s};
      OP_HU:   load_o = {16'd0, half_s};
      OP_W:    load_o = word_i;
      default: load_o = 32'd0;
    endcase
  end

  // Store path: overwrite the addressed lane(s) of the fetched word
  always_comb begin
    merge_o = word_i;
    case (op_i)
      OP_B: begin
        case (off_i)
          2'd0:    merge_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          2'd3:    merge_o[31:24] = wdata_i[7:0];
          default: merge_o = word_i;
        endcase
      end
      OP_H: begin
        if (off_i[1]) begin
          merge_o[31:16] = wdata_i[15:0];
        end else begin
          merge_o[15:0] = wdata_i[15:0];
        end
      end
      OP_W:    merge_o = wdata_i;
      default: merge_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-indexed dmem; sub-word stores to non-zero
// lanes are performed as a read-modify-write. All dm_* outputs are registered.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_ena,
  output logic        dm_w,
  output logic        dm_r,
  output logic [2:0]  dm_sel,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        dm_ena_q, dm_ena_d, dm_w_q, dm_w_d, dm_r_q, dm_r_d;
  logic [2:0]  dm_sel_q, dm_sel_d;
  logic [31:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;

  logic        req_illegal_s;
  logic [31:0] req_word_s;
  logic [31:0] load_s, merge_s;

  assign req_illegal_s = op_illegal(req_we, req_op, req_addr[1:0]) |
                         ((req_addr >> (AW + 2)) != 32'd0);
  assign req_word_s    = {{(32 - AW){1'b0}}, req_addr[AW+1:2]};

  lsu_lane u_lane (
    .op_i    (op_q),
    .off_i   (off_q),
    .word_i  (dm_rdata),
    .wdata_i (wdata_q),
    .load_o  (load_s),
    .merge_o (merge_s)
  );

  // Next-state and next-output decode; dm_* are computed for the state being entered
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    op_d         = op_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    dm_ena_d     = 1'b0;
    dm_w_d       = 1'b0;
    dm_r_d       = 1'b0;
    dm_sel_d     = 3'b000;
    dm_addr_d    = 32'd0;
    dm_wdata_d   = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          op_d    = req_op;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          if (req_illegal_s) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d   = ST_ACC;
            dm_ena_d  = 1'b1;
            dm_addr_d = req_word_s;
            if (req_we && !needs_rmw(req_op, req_addr[1:0])) begin
              dm_w_d     = 1'b1;
              dm_sel_d   = store_sel(req_op);
              dm_wdata_d = req_wdata;
            end else begin
              dm_r_d   = 1'b1;
              dm_sel_d = SEL_W;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (!we_q) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_s;
        end else if (needs_rmw(op_q, off_q)) begin
          // merged word is held in dm_wdata for the write-back cycle
          state_d    = ST_RMW_WR;
          dm_ena_d   = 1'b1;
          dm_w_d     = 1'b1;
          dm_sel_d   = SEL_W;
          dm_addr_d  = dm_addr_q;
          dm_wdata_d = merge_s;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'd0;
        end
      end
      ST_RMW_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'd0;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      op_q         <= 3'b000;
      off_q        <= 2'b00;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      dm_ena_q     <= 1'b0;
      dm_w_q       <= 1'b0;
      dm_r_q       <= 1'b0;
      dm_sel_q     <= 3'b000;
      dm_addr_q    <= 32'd0;
      dm_wdata_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      op_q         <= op_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      dm_ena_q     <= dm_ena_d;
      dm_w_q       <= dm_w_d;
      dm_r_q       <= dm_r_d;
      dm_sel_q     <= dm_sel_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign dm_ena     = dm_ena_q;
  assign dm_w       = dm_w_q;
  assign dm_r       = dm_r_q;
  assign dm_sel     = dm_sel_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: a word-indexed dmem model, a byte-level reference
// model of load/store semantics, directed vectors and randomized traffic.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        dm_ena, dm_w, dm_r;
  logic [2:0]  dm_sel;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  always #5 clk = ~clk;

  dmem_lsu #(.AW(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_ena(dm_ena), .dm_w(dm_w), .dm_r(dm_r), .dm_sel(dm_sel),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // dmem: combinational read, sub-word writes hit the low lanes only
  logic [31:0] mem [0:1023];
  logic        mem_init;
  assign dm_rdata = mem[dm_addr[9:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else if (dm_ena && dm_w) begin
      case (dm_sel)
        3'b100:  mem[dm_addr[9:0]][7:0]  <= dm_wdata[7:0];
        3'b010:  mem[dm_addr[9:0]][15:0] <= dm_wdata[15:0];
        default: mem[dm_addr[9:0]]       <= dm_wdata;
      endcase
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] refmem [0:4095];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Byte-addressed reference: computes response and updates refmem
  task automatic ref_op(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lt);
    int size, a;
    logic [31:0] v;
    size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    er = (op == 3'd3) || (op == 3'd6) || (op == 3'd7) || (we && op[2]) ||
         (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'd0) ||
         (addr >= 32'h1000);
    rd = 32'd0;
    lt = 1;
    if (!er) begin
      a = int'(addr);
      if (we) begin
        for (int i = 0; i < size; i++) refmem[a + i] = wd[8*i +: 8];
        lt = (size < 4 && addr[1:0] != 2'd0) ? 3 : 2;
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = refmem[a + i];
        if (!op[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!op[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
        rd = v;
        lt = 2;
      end
    end
  endtask

  logic [31:0] o_rdata, o_wdata, o_waddr;
  logic        o_err, o_both, o_stable;
  logic [2:0]  o_wsel;
  int          o_lat, o_rd, o_wr, o_ena;

  // One full request/response handshake, observing the dmem port throughout
  task automatic xact(input logic we, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input int hold);
    int guard;
    logic done;
    o_rd = 0; o_wr = 0; o_ena = 0; o_both = 1'b0; o_wsel = 3'd0;
    o_wdata = 32'd0; o_waddr = 32'd0; o_stable = 1'b1; o_rdata = 32'd0; o_err = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    o_lat = 1;
    done = 1'b0;
    while (!done) begin
      if (dm_ena) o_ena++;
      if (dm_ena && dm_r) o_rd++;
      if (dm_ena && dm_w) begin
        o_wr++; o_wsel = dm_sel; o_wdata = dm_wdata; o_waddr = dm_addr;
      end
      if (dm_w && dm_r) o_both = 1'b1;
      if (resp_valid || o_lat >= 8) begin
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        o_lat++;
      end
    end
    if (!resp_valid) begin
      chk("resp_timeout", {31'd0, resp_valid}, 32'd1);
      return;
    end
    o_rdata = resp_rdata;
    o_err   = resp_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_rdata !== o_rdata || resp_err !== o_err || req_ready || dm_ena)
        o_stable = 1'b0;
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    if (resp_valid || resp_rdata !== 32'd0 || resp_err || !req_ready) o_stable = 1'b0;
  endtask

  // Run one request through model and DUT; table vectors supply their own expectations
  task automatic apply(input string tag, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold,
                       input logic use_tab, input logic [31:0] t_rd, input logic t_er,
                       input int t_lt);
    logic [31:0] e_rd, e_word;
    logic        e_er;
    int          e_lt, wa;
    logic [2:0]  e_sel;
    ref_op(we, op, addr, wd, e_rd, e_er, e_lt);
    if (use_tab) begin
      e_rd = t_rd; e_er = t_er; e_lt = t_lt;
    end
    xact(we, op, addr, wd, hold);
    chk({tag, " rdata"}, o_rdata, e_rd);
    chk({tag, " err"}, {31'd0, o_err}, {31'd0, e_er});
    chk({tag, " latency"}, 32'(o_lat), 32'(e_lt));
    chk({tag, " rw_exclusive"}, {31'd0, o_both}, 32'd0);
    chk({tag, " resp_stable"}, {31'd0, o_stable}, 32'd1);
    if (e_er) begin
      chk({tag, " no_access"}, 32'(o_ena), 32'd0);
    end else if (we) begin
      e_sel = (e_lt == 3) ? 3'b001 : (op[1:0] == 2'd0) ? 3'b100 :
              (op[1:0] == 2'd1) ? 3'b010 : 3'b001;
      wa = int'({addr[31:2], 2'b00});
      e_word = {refmem[wa + 3], refmem[wa + 2], refmem[wa + 1], refmem[wa]};
      chk({tag, " writes"}, 32'(o_wr), 32'd1);
      chk({tag, " reads"}, 32'(o_rd), (e_lt == 3) ? 32'd1 : 32'd0);
      chk({tag, " wsel"}, {29'd0, o_wsel}, {29'd0, e_sel});
      chk({tag, " waddr"}, o_waddr, {2'b00, addr[31:2]});
      chk({tag, " wdata"}, o_wdata, (e_lt == 3) ? e_word : wd);
    end else begin
      chk({tag, " reads"}, 32'(o_rd), 32'd1);
      chk({tag, " writes"}, 32'(o_wr), 32'd0);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    int          hold;
    logic [31:0] rd;
    logic        er;
    int          lt;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wd, input int hold, input logic [31:0] rd,
                              input logic er, input int lt);
    vec_t v;
    v.we = we; v.op = op; v.addr = addr; v.wd = wd; v.hold = hold;
    v.rd = rd; v.er = er; v.lt = lt;
    return v;
  endfunction

  vec_t tab [21];
  logic [2:0] ops [5];

  initial begin
    logic [31:0] w, addr, e_rd;
    logic        e_er;
    int          e_lt, r;
    logic [2:0]  op;

    tab[0]  = mk(1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 0, 32'h0,        1'b0, 2);
    tab[1]  = mk(1'b0, 3'b010, 32'h10,  32'h0,        5, 32'hDEADBEEF, 1'b0, 2);
    tab[2]  = mk(1'b1, 3'b010, 32'h10,  32'h80FF7F01, 0, 32'h0,        1'b0, 2);
    tab[3]  = mk(1'b0, 3'b000, 32'h13,  32'h0,        0, 32'hFFFFFF80, 1'b0, 2);
    tab[4]  = mk(1'b0, 3'b100, 32'h13,  32'h0,        0, 32'h00000080, 1'b0, 2);
    tab[5]  = mk(1'b0, 3'b001, 32'h12,  32'h0,        0, 32'hFFFF80FF, 1'b0, 2);
    tab[6]  = mk(1'b0, 3'b101, 32'h10,  32'h0,        0, 32'h00007F01, 1'b0, 2);
    tab[7]  = mk(1'b1, 3'b010, 32'h10,  32'h11223344, 0, 32'h0,        1'b0, 2);
    tab[8]  = mk(1'b1, 3'b000, 32'h11,  32'h000000AB, 0, 32'h0,        1'b0, 3);
    tab[9]  = mk(1'b0, 3'b010, 32'h10,  32'h0,        0, 32'h1122AB44, 1'b0, 2);
    tab[10] = mk(1'b1, 3'b001, 32'h10,  32'h00005566, 0, 32'h0,        1'b0, 2);
    tab[11] = mk(1'b0, 3'b010, 32'h10,  32'h0,        0, 32'h11225566, 1'b0, 2);
    tab[12] = mk(1'b0, 3'b010, 32'h12,  32'h0,        0, 32'h0,        1'b1, 1);
    tab[13] = mk(1'b1, 3'b001, 32'h11,  32'h00001234, 0, 32'h0,        1'b1, 1);
    tab[14] = mk(1'b1, 3'b100, 32'h10,  32'h000000CD, 0, 32'h0,        1'b1, 1);
    tab[15] = mk(1'b0, 3'b010, 32'h1000, 32'h0,       0, 32'h0,        1'b1, 1);
    tab[16] = mk(1'b0, 3'b011, 32'h10,  32'h0,        2, 32'h0,        1'b1, 1);
    tab[17] = mk(1'b1, 3'b001, 32'h12,  32'h00009988, 0, 32'h0,        1'b0, 3);
    tab[18] = mk(1'b0, 3'b010, 32'h10,  32'h0,        3, 32'h99885566, 1'b0, 2);
    tab[19] = mk(1'b1, 3'b000, 32'hFFF, 32'h0000007F, 0, 32'h0,        1'b0, 3);
    tab[20] = mk(1'b0, 3'b100, 32'hFFF, 32'h0,        0, 32'h0000007F, 1'b0, 2);
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100; ops[4] = 3'b101;

    for (int i = 0; i < 1024; i++) begin
      w = init_word(i);
      for (int b = 0; b < 4; b++) refmem[4*i + b] = w[8*b +: 8];
    end
    rst_n = 1'b0; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset resp", {resp_rdata[29:0], resp_valid, resp_err}, 32'd0);
    chk("reset dm_ctl", {26'd0, dm_ena, dm_w, dm_r, dm_sel}, 32'd0);
    chk("reset dm_addr", dm_addr, 32'd0);
    mem_init = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 21; i++)
      apply($sformatf("vec%0d", i), tab[i].we, tab[i].op, tab[i].addr, tab[i].wd,
            tab[i].hold, 1'b1, tab[i].rd, tab[i].er, tab[i].lt);

    // Reset during the read half of an RMW store: the write must never happen
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b000; req_addr = 32'h11; req_wdata = 32'hAB;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw read cycle", {26'd0, dm_ena, dm_w, dm_r, dm_sel}, {26'd0, 3'b101, 3'b001});
    rst_n = 1'b0;
    #1;
    chk("async reset dm_ctl", {26'd0, dm_ena, dm_w, dm_r, dm_sel}, 32'd0);
    chk("async reset dm_addr", dm_addr, 32'd0);
    chk("async reset dm_wdata", dm_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post reset req_ready", {31'd0, req_ready}, 32'd1);
    apply("post reset lw", 1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b1, 32'h99885566, 1'b0, 2);

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 15));
      op = (r < 14) ? ops[r % 5] : ((r == 14) ? 3'b011 : 3'b111);
      addr = 32'($urandom_range(0, 95));
      if ($urandom_range(0, 19) == 0) addr = addr | 32'h1000 | ($urandom & 32'hFFFF_F000);
      apply($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), op, addr, $urandom,
            int'($urandom_range(0, 2)), 1'b0, 32'd0, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit that acts as the initiator toward the data memory. It takes byte-addressed CPU load/store requests, drives the dmem port (dm_ena/dm_w/dm_r/dm_sel/addr/dm_in), and returns sign- or zero-extended load data.
- The dmem is word-indexed, and its sub-word writes only touch the low lanes. Sub-word stores at a non-zero byte offset are therefore done as a read-modify-write (RMW).
- Sits between the CPU execute/memory stage and dmem.

Parameters:
- AW, 10, log2 of dmem depth in 32-bit words; byte addresses at or above 4*2^AW are out of range.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned (unsigned ops are loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, taken from the low lanes
- resp_valid  out  1  response available
- resp_ready  in  1  CPU consumes the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal op
- dm_ena  out  1  dmem enable
- dm_w  out  1  dmem write
- dm_r  out  1  dmem read
- dm_sel  out  3  100 byte, 010 half, 001 word
- dm_addr  out  32  word index = {zeros, byte_addr[AW+1:2]}
- dm_wdata  out  32  dmem write data
- dm_rdata  in  32  dmem read data, combinational from dm_addr

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; resp_valid=0, resp_rdata=0, resp_err=0, all request registers cleared.
  - dm_ena/dm_w/dm_r=0, dm_sel=000, dm_addr=0, dm_wdata=0.
  - Reset mid-operation abandons the access. A pending RMW write is never issued.
- States: IDLE, ACC, RMW_WR, RESP.
- IDLE:
  - req_ready=1 (combinational from state); all dm_* are 0.
  - On req_valid, register we/op/addr/wdata and check legality.
  - Illegal: unsigned op with we=1; op not in the list above; half with addr[0]=1; word with addr[1:0]!=0; addr[31:AW+2]!=0.
  - Illegal request: go to RESP with resp_err=1 and resp_rdata=0. No dmem access occurs.
  - Legal request: go to ACC.
- ACC (exactly one cycle, dm_ena=1, dm_addr = word index):
  - Load: dm_r=1, dm_sel=001. Lane extract: byte = rdata[8*off+7 : 8*off], half = rdata[16*h+15 : 16*h]. Sign-extend, or zero-extend for unsigned. Register the result into resp_rdata. Go to RESP.
  - sw, or sb/sh at offset 0: dm_w=1, dm_r=0, dm_sel = 001 / 100 / 010 respectively, dm_wdata=req_wdata. Go to RESP.
  - sb at offset 1..3, or sh at offset 2: dm_r=1, dm_sel=001. Capture dm_rdata, merge the store lane(s) into it, hold the merged word. Go to RMW_WR.
- RMW_WR (one cycle): dm_ena=1, dm_w=1, dm_r=0, dm_sel=001, same dm_addr, dm_wdata = merged word. Go to RESP.
- RESP:
  - resp_valid=1; resp_rdata/resp_err stay stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE and clear resp_valid, resp_rdata and resp_err.
  - Back-to-back: a new request can be accepted the cycle after the handshake (one IDLE bubble).
- Latency from request accept edge to resp_valid:
  - Load or single-cycle store: 2 cycles.
  - RMW store: 3 cycles.
  - Error: 1 cycle.
- dm_w and dm_r are never both 1. dm_* outputs are registered (state-decoded, glitch-free).
- req_valid is ignored outside IDLE.

Decomposition:
- Package dmem_lsu_pkg:
  - op codes (OP_B, OP_H, OP_W, OP_BU, OP_HU);
  - dm_sel codes (SEL_B=100, SEL_H=010, SEL_W=001);
  - state enum.
- One sub-module, lsu_lane: purely combinational; does load extract/extend and store merge from (op, offset, word, wdata).

Test Plan:
- Store then load word: sw 0xDEADBEEF @0x10 → ACC cycle shows dm_addr=4, dm_sel=001, dm_w=1. Then lw @0x10 → resp_rdata=0xDEADBEEF, err=0, resp_valid 2 cycles after accept.
- Sub-word loads with extension, memory word 4 = 0x80FF7F01:
  - lb @0x13 → 0xFFFFFF80; lbu @0x13 → 0x00000080;
  - lh @0x12 → 0xFFFF80FF; lhu @0x10 → 0x00007F01.
- RMW store: word 4 = 0x11223344, sb 0xAB @0x11 → read cycle, then write cycle with dm_wdata=0x1122AB44, dm_sel=001. Resp 3 cycles after accept; a following lw returns 0x1122AB44.
- Direct sub-word store: sh 0x5566 @0x10 → single write cycle, dm_sel=010, dm_wdata[15:0]=0x5566, no read cycle.
- Errors, each giving resp_err=1, resp_rdata=0, dm_ena never 1:
  - lw @0x12; sh @0x11; sb with req_op=100; lw @0x1000 (AW=10).
- Backpressure and reset:
  - Hold resp_ready=0 for 5 cycles → resp_valid and resp_rdata stable, req_ready=0.
  - Assert rst_n low during RMW ACC → all dm_* go 0 immediately, the word is unchanged afterwards, and req_ready=1 after reset.
